// File: rtl/vram_arbiter_if.sv
// Bus bundle for vram_arbiter: CPU port, video fetch port and synchronous RAM port.
// The arbiter uses the slave modport; the CPU/video/RAM side uses the master modport.
interface vram_arbiter_if;
  logic [11:0] CPU_ADDR;
  logic [7:0]  CPU_DIN;
  logic [7:0]  CPU_DOUT;
  logic        CPU_CS;
  logic        CPU_RD;
  logic        CPU_WR;
  logic        CPU_WAIT_N;
  logic [11:0] VGA_ADDR;
  logic [7:0]  VGA_DATA;
  logic        BUS_REQ;
  logic        BUS_ACK;
  logic [11:0] RAM_ADDR;
  logic [7:0]  RAM_WDATA;
  logic        RAM_WE;
  logic [7:0]  RAM_RDATA;

  modport slave (
    input  CPU_ADDR, CPU_DIN, CPU_CS, CPU_RD, CPU_WR, VGA_ADDR, BUS_REQ, RAM_RDATA,
    output CPU_DOUT, CPU_WAIT_N, VGA_DATA, BUS_ACK, RAM_ADDR, RAM_WDATA, RAM_WE
  );

  modport master (
    output CPU_ADDR, CPU_DIN, CPU_CS, CPU_RD, CPU_WR, VGA_ADDR, BUS_REQ, RAM_RDATA,
    input  CPU_DOUT, CPU_WAIT_N, VGA_DATA, BUS_ACK, RAM_ADDR, RAM_WDATA, RAM_WE
  );
endinterface

// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares a 1-cycle-latency synchronous RAM between a CPU and a video fetcher.
// Define VRAM_POSTED_WRITE_EN to add a single-entry posted write buffer for CPU writes.
module vram_arbiter (
  input  logic          CLK_50MHZ,
  input  logic          RST_N,
  vram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CPU_ACC, CPU_DONE, VIDEO} state_e;

  state_e      state_q, state_d;
  logic        strobe, strobe_q, capture, toBuf, startAcc;
  logic        pending_q, isWrite_q, waitN_q, busAck_q, wasVideo_q;
  logic        accWrite_q, accBuf_q;
  logic [11:0] cpuAddr_q, ramAddr_q;
  logic [7:0]  cpuDin_q, ramWdata_q, cpuDout_q;
  logic        bufValid;
  logic [11:0] bufAddr;
  logic [7:0]  bufData;

  assign strobe  = bus.CPU_CS & (bus.CPU_RD | bus.CPU_WR);
  assign capture = strobe & ~strobe_q & ~pending_q;

`ifdef VRAM_POSTED_WRITE_EN
  logic        bufValid_q;
  logic [11:0] bufAddr_q;
  logic [7:0]  bufData_q;

  // A write finding the buffer empty is posted; it drains before any pending CPU op.
  assign toBuf    = capture & bus.CPU_WR & ~bufValid_q;
  assign bufValid = bufValid_q;
  assign bufAddr  = bufAddr_q;
  assign bufData  = bufData_q;

  always_ff @(posedge CLK_50MHZ) begin
    if (!RST_N) begin
      bufValid_q <= 1'b0;
      bufAddr_q  <= '0;
      bufData_q  <= '0;
    end else if (toBuf) begin
      bufValid_q <= 1'b1;
      bufAddr_q  <= bus.CPU_ADDR;
      bufData_q  <= bus.CPU_DIN;
    end else if (state_q == CPU_DONE && accBuf_q) begin
      bufValid_q <= 1'b0;
    end
  end
`else
  assign toBuf    = 1'b0;
  assign bufValid = 1'b0;
  assign bufAddr  = '0;
  assign bufData  = '0;
`endif

  always_ff @(posedge CLK_50MHZ) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Video wins in IDLE, but a started CPU access always runs through CPU_DONE.
  always_comb begin
    state_d  = state_q;
    startAcc = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.BUS_REQ) begin
          state_d = VIDEO;
        end else if (pending_q || bufValid) begin
          state_d  = CPU_ACC;
          startAcc = 1'b1;
        end
      end
      CPU_ACC:  state_d = CPU_DONE;
      CPU_DONE: state_d = bus.BUS_REQ ? VIDEO : IDLE;
      VIDEO:    if (!bus.BUS_REQ) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (!RST_N) begin
      strobe_q   <= 1'b0;
      pending_q  <= 1'b0;
      isWrite_q  <= 1'b0;
      cpuAddr_q  <= '0;
      cpuDin_q   <= '0;
      waitN_q    <= 1'b1;
      busAck_q   <= 1'b0;
      wasVideo_q <= 1'b0;
      accWrite_q <= 1'b0;
      accBuf_q   <= 1'b0;
      ramAddr_q  <= '0;
      ramWdata_q <= '0;
      cpuDout_q  <= '0;
    end else begin
      strobe_q   <= strobe;
      busAck_q   <= (state_d == VIDEO);
      wasVideo_q <= (state_q == VIDEO);
      if (capture && !toBuf) begin
        pending_q <= 1'b1;
        isWrite_q <= bus.CPU_WR;
        cpuAddr_q <= bus.CPU_ADDR;
        cpuDin_q  <= bus.CPU_DIN;
        waitN_q   <= 1'b0;
      end
      // The RAM port is loaded once per access and then held, so RAM_WDATA keeps its last value.
      if (startAcc) begin
        accBuf_q   <= bufValid;
        accWrite_q <= bufValid | isWrite_q;
        ramAddr_q  <= bufValid ? bufAddr : cpuAddr_q;
        if (bufValid)       ramWdata_q <= bufData;
        else if (isWrite_q) ramWdata_q <= cpuDin_q;
      end
      if (state_q == CPU_DONE && !accBuf_q) begin
        pending_q <= 1'b0;
        waitN_q   <= 1'b1;
        if (!accWrite_q) cpuDout_q <= bus.RAM_RDATA;
      end
    end
  end

  // Gating the strobe with RST_N keeps a reset during CPU_ACC from committing the write.
  assign bus.RAM_WE     = (state_q == CPU_ACC) & accWrite_q & RST_N;
  assign bus.RAM_ADDR   = (state_q == VIDEO) ? bus.VGA_ADDR : ramAddr_q;
  assign bus.RAM_WDATA  = ramWdata_q;
  assign bus.CPU_DOUT   = cpuDout_q;
  assign bus.CPU_WAIT_N = waitN_q;
  assign bus.BUS_ACK    = busAck_q;
  assign bus.VGA_DATA   = wasVideo_q ? bus.RAM_RDATA : 8'h00;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: RAM model, transaction-level reference model and directed scenarios.
// Expectations that differ with the posted write buffer follow VRAM_POSTED_WRITE_EN.
module tb_vram_arbiter;

  logic clk;
  logic rstN;
  int   checks;
  int   errors;

  vram_arbiter_if bus ();

  vram_arbiter dut (
    .CLK_50MHZ (clk),
    .RST_N     (rstN),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM with one clock of read latency plus a preload port for the bench.
  logic [7:0]  mem [4096];
  logic        preWe;
  logic [11:0] preAddr;
  logic [7:0]  preData;

  always @(posedge clk) begin
    if (preWe)           mem[preAddr] <= preData;
    else if (bus.RAM_WE) mem[bus.RAM_ADDR] <= bus.RAM_WDATA;
    bus.RAM_RDATA <= mem[bus.RAM_ADDR];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Reference model: memory contents, expected write order, expected CPU read data and grant latency.
  logic [7:0]  refMem [4096];
  logic [19:0] expWrQ [$];
  logic [7:0]  expDout;
  logic [11:0] readAddr, prevVgaAddr;
  bit          readPend, prevAck, prevStrobe, prevWaitN;
  int          reqAge;

  always @(negedge clk) begin
    logic modelStrobe;
    if (!rstN) begin
      expWrQ.delete();
      readPend   = 1'b0;
      expDout    = 8'h00;
      prevAck    = 1'b0;
      prevStrobe = 1'b0;
      prevWaitN  = 1'b1;
      reqAge     = 0;
    end else begin
      if (preWe) refMem[preAddr] = preData;
      if (bus.RAM_WE) begin
        if (expWrQ.size() == 0) begin
          checkOutput("ramWriteUnexpected", expWrQ.size(), 1);
        end else begin
          checkOutput("ramWrite", {bus.RAM_ADDR, bus.RAM_WDATA}, expWrQ[0]);
          refMem[expWrQ[0][19:8]] = expWrQ[0][7:0];
          void'(expWrQ.pop_front());
        end
      end
      if (bus.BUS_ACK) checkOutput("videoBus", {bus.RAM_WE, bus.RAM_ADDR}, {1'b0, bus.VGA_ADDR});
      checkOutput("vgaData", bus.VGA_DATA, prevAck ? refMem[prevVgaAddr] : 8'h00);
      modelStrobe = bus.CPU_CS & (bus.CPU_RD | bus.CPU_WR);
      if (modelStrobe && !prevStrobe) begin
        if (bus.CPU_WR) expWrQ.push_back({bus.CPU_ADDR, bus.CPU_DIN});
        else begin
          readPend = 1'b1;
          readAddr = bus.CPU_ADDR;
        end
      end
      if (bus.CPU_WAIT_N && !prevWaitN && readPend) begin
        expDout  = refMem[readAddr];
        readPend = 1'b0;
      end
      checkOutput("cpuDout", bus.CPU_DOUT, expDout);
      if (!bus.BUS_REQ) reqAge = 0;
      else if (!bus.BUS_ACK) begin
        reqAge++;
        if (reqAge == 4) checkOutput("ackLate", reqAge, 3);
      end
      if (bus.BUS_ACK && !prevAck) checkOutput("ackWithin3", (reqAge <= 3), 1);
      prevAck     = bus.BUS_ACK;
      prevVgaAddr = bus.VGA_ADDR;
      prevStrobe  = modelStrobe;
      prevWaitN   = bus.CPU_WAIT_N;
    end
  end

  task automatic preloadWord(input logic [11:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    preWe   = 1'b1;
    preAddr = a;
    preData = d;
  endtask

  // One CPU access; waitLow counts clocks with CPU_WAIT_N low after the capture edge.
  task automatic applyStimulus(input bit wr, input logic [11:0] addr, input logic [7:0] data,
                               output int waitLow);
    bit done;
    @(posedge clk); #1;
    bus.CPU_CS   = 1'b1;
    bus.CPU_RD   = !wr;
    bus.CPU_WR   = wr;
    bus.CPU_ADDR = addr;
    bus.CPU_DIN  = data;
    @(negedge clk);
    waitLow = 0;
    done    = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.CPU_WAIT_N) done = 1'b1;
      else                waitLow++;
    end
    if (!done) checkOutput("cpuWaitBound", done, 1);
    @(posedge clk); #1;
    bus.CPU_CS = 1'b0;
    bus.CPU_RD = 1'b0;
    bus.CPU_WR = 1'b0;
  endtask

  // Video window of n clocks with VGA_ADDR stepping 0..n-1; lat is clocks from request to grant.
  task automatic runVideo(input int n, output int lat);
    bit seen;
    seen = 1'b0;
    lat  = -1;
    @(posedge clk); #1;
    bus.BUS_REQ = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.VGA_ADDR = 12'(i);
      @(negedge clk);
      if (!seen && bus.BUS_ACK) begin
        seen = 1'b1;
        lat  = i;
      end
      if (i == n - 1) checkOutput("vgaDataLast", bus.VGA_DATA, 8'(n - 2));
      @(posedge clk); #1;
    end
    bus.BUS_REQ = 1'b0;
    @(negedge clk);
    checkOutput("ackHeld", bus.BUS_ACK, 1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("ackDrop", bus.BUS_ACK, 0);
  endtask

  initial begin
    int wl, wl2, lat;
    int expPostWait;
`ifdef VRAM_POSTED_WRITE_EN
    expPostWait = 0;
`else
    expPostWait = 3;
`endif
    checks       = 0;
    errors       = 0;
    rstN         = 1'b0;
    preWe        = 1'b0;
    preAddr      = '0;
    preData      = '0;
    bus.CPU_ADDR = '0;
    bus.CPU_DIN  = '0;
    bus.CPU_CS   = 1'b0;
    bus.CPU_RD   = 1'b0;
    bus.CPU_WR   = 1'b0;
    bus.VGA_ADDR = '0;
    bus.BUS_REQ  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstWaitN", bus.CPU_WAIT_N, 1);
    checkOutput("rstAck", bus.BUS_ACK, 0);
    checkOutput("rstWe", bus.RAM_WE, 0);
    checkOutput("rstRamAddr", bus.RAM_ADDR, 0);
    checkOutput("rstWdata", bus.RAM_WDATA, 0);
    checkOutput("rstDout", bus.CPU_DOUT, 0);
    checkOutput("rstVgaData", bus.VGA_DATA, 0);
    @(posedge clk); #1;
    rstN = 1'b1;

    for (int n = 0; n < 40; n++) preloadWord(12'(n), 8'(n));
    preloadWord(12'h123, 8'h5A);
    preloadWord(12'hFFF, 8'h77);
    preloadWord(12'h400, 8'h99);
    @(posedge clk); #1;
    preWe = 1'b0;

    applyStimulus(1'b0, 12'h123, 8'h00, wl);
    checkOutput("idleReadWait", wl, 3);
    checkOutput("idleReadData", bus.CPU_DOUT, 8'h5A);

    applyStimulus(1'b1, 12'h200, 8'h3C, wl);
    checkOutput("writeWait", wl, expPostWait);
    applyStimulus(1'b0, 12'h200, 8'h00, wl);
    checkOutput("readBackWait", wl, 3);
    checkOutput("readBackData", bus.CPU_DOUT, 8'h3C);

    runVideo(40, lat);
    checkOutput("ackLatencyIdle", lat, 1);

    fork
      applyStimulus(1'b1, 12'h010, 8'hAA, wl);
      begin
        repeat (2) @(posedge clk);
        runVideo(10, lat);
      end
    join
    checkOutput("collisionWait", wl, expPostWait);
    checkOutput("collisionAckLat", lat, 2);
    checkOutput("collisionMem", mem[12'h010], 8'hAA);

    fork
      runVideo(12, lat);
      begin
        repeat (4) @(posedge clk);
        applyStimulus(1'b0, 12'h005, 8'h00, wl);
      end
    join
    checkOutput("blockedReadWait", wl, 11);
    checkOutput("blockedReadData", bus.CPU_DOUT, 8'h05);

    fork
      begin
        runVideo(10, lat);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("postedMem", mem[12'hFFF], 8'h11);
      end
      begin
        repeat (3) @(posedge clk);
        applyStimulus(1'b1, 12'hFFF, 8'h11, wl);
      end
    join
`ifdef VRAM_POSTED_WRITE_EN
    checkOutput("postedWait", wl, 0);
`else
    checkOutput("postedWait", wl, 10);
`endif

    fork
      runVideo(10, lat);
      begin
        repeat (2) @(posedge clk);
        applyStimulus(1'b1, 12'h300, 8'h22, wl);
        applyStimulus(1'b0, 12'h300, 8'h00, wl2);
      end
    join
    checkOutput("readAfterWriteData", bus.CPU_DOUT, 8'h22);
`ifdef VRAM_POSTED_WRITE_EN
    checkOutput("readBehindBufferWait", wl2, 11);
`else
    checkOutput("readBehindBufferWait", wl2, 3);
`endif

    repeat (3) @(posedge clk);
    checkOutput("writeQueueDrained", expWrQ.size(), 0);

    @(posedge clk); #1;
    bus.CPU_CS   = 1'b1;
    bus.CPU_WR   = 1'b1;
    bus.CPU_RD   = 1'b0;
    bus.CPU_ADDR = 12'h400;
    bus.CPU_DIN  = 8'h66;
    repeat (2) @(posedge clk);
    #1;
    rstN       = 1'b0;
    bus.CPU_CS = 1'b0;
    bus.CPU_WR = 1'b0;
    @(negedge clk);
    checkOutput("weGatedInReset", bus.RAM_WE, 0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("resetWaitN", bus.CPU_WAIT_N, 1);
    checkOutput("resetWe", bus.RAM_WE, 0);
    @(posedge clk); #1;
    rstN = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetMemUnchanged", mem[12'h400], 8'h99);
    checkOutput("resetDout", bus.CPU_DOUT, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The block SHALL expose: CLK_50MHZ  in  1  system clock; all logic on its rising edge.
REQ-002 The block SHALL expose: RST_N  in  1  reset, synchronous, active-low.
REQ-003 The block SHALL expose: CPU_ADDR  in  12  CPU VRAM address; CPU_DIN  in  8  CPU write data; CPU_DOUT  out  8  CPU read data.
REQ-004 The block SHALL expose: CPU_CS  in  1  VRAM select; CPU_RD  in  1  read strobe; CPU_WR  in  1  write strobe. All are synchronous to CLK_50MHZ.
REQ-005 The block SHALL expose: CPU_WAIT_N  out  1  CPU wait, low = hold the CPU.
REQ-006 The block SHALL expose: VGA_ADDR  in  12  video fetch address; VGA_DATA  out  8  video fetch data; BUS_REQ  in  1  video window request; BUS_ACK  out  1  video grant.
REQ-007 The block SHALL expose: RAM_ADDR  out  12; RAM_WDATA  out  8; RAM_WE  out  1; RAM_RDATA  in  8. The RAM is synchronous with 1-clock read latency.

Function
REQ-010 Strobe SHALL be defined as CPU_CS & (CPU_RD | CPU_WR); a CPU request SHALL be captured only on its rising edge (strobe high, registered strobe low).
REQ-011 At capture, the block SHALL latch CPU_ADDR, CPU_DIN and direction (write if CPU_WR, else read), set a pending flag, and drive CPU_WAIT_N low from the next clock.
REQ-012 The FSM SHALL have the states IDLE, CPU_ACC, CPU_DONE and VIDEO.
REQ-013 IDLE: if BUS_REQ, go to VIDEO; else if an operation is pending, go to CPU_ACC; else stay in IDLE. BUS_REQ SHALL win when both are present.
REQ-014 CPU_ACC (1 clock): RAM_ADDR = latched address; RAM_WE = 1 for a write, with RAM_WDATA = latched data; then go to CPU_DONE.
REQ-015 CPU_DONE (1 clock): for a read, capture RAM_RDATA into CPU_DOUT; clear pending; raise CPU_WAIT_N on the next clock; go to VIDEO if BUS_REQ, else IDLE.
REQ-016 CPU_DOUT SHALL hold its value until the next completed read.
REQ-017 An in-flight CPU access SHALL never be aborted by BUS_REQ. BUS_ACK SHALL assert no more than 3 clocks after BUS_REQ rises.
REQ-018 VIDEO: BUS_ACK = 1 (registered), RAM_ADDR = VGA_ADDR, RAM_WE = 0. Stay while BUS_REQ = 1. When BUS_REQ = 0, BUS_ACK drops on the next clock and the FSM goes to IDLE.
REQ-019 VGA_DATA SHALL equal RAM_RDATA when the previous-clock state was VIDEO, otherwise 8'h00.
REQ-020 A strobe edge arriving while a request is pending SHALL be ignored. The CPU holds its strobe until CPU_WAIT_N is high.
REQ-021 Outside CPU_ACC, RAM_WE SHALL be 0 and RAM_WDATA SHALL hold its last value.
REQ-022 The 12-bit addresses SHALL pass through unmodified; there is no wrap or offset arithmetic.

Reset
REQ-030 While RST_N = 0 at a clock edge: FSM = IDLE, BUS_ACK = 0, CPU_WAIT_N = 1, RAM_WE = 0, RAM_ADDR = 0, RAM_WDATA = 0, CPU_DOUT = 0, VGA_DATA = 0, pending = 0, registered strobe = 0, posted buffer empty.
REQ-031 Reset asserted mid-access SHALL discard the pending or buffered write with no RAM write, and release CPU_WAIT_N on that same reset clock.

Configuration
REQ-040 The macro VRAM_POSTED_WRITE_EN SHALL enable a single-entry posted write buffer.
REQ-041 With VRAM_POSTED_WRITE_EN defined: a write captured while the buffer is empty SHALL enter the buffer and keep CPU_WAIT_N high.
REQ-042 With VRAM_POSTED_WRITE_EN defined: the buffer drains through CPU_ACC/CPU_DONE under the same priority rules as REQ-013.
REQ-043 With VRAM_POSTED_WRITE_EN defined: a write captured while the buffer is full SHALL wait as in REQ-011.
REQ-044 With VRAM_POSTED_WRITE_EN defined: any read captured while the buffer is full SHALL wait until the buffer has drained and the read has completed.
REQ-045 Without VRAM_POSTED_WRITE_EN: no buffer exists, and all writes wait per REQ-011.

Verification
REQ-050 Idle read: RAM[12'h123] = 8'h5A; CPU read of 12'h123 -> CPU_WAIT_N low for 3 clocks, then CPU_DOUT = 8'h5A.
REQ-051 Video fetch: BUS_REQ held 40 clocks, VGA_ADDR stepping 0..39 over RAM[n] = n -> BUS_ACK high within 3 clocks; VGA_DATA = n one clock after each address; RAM_WE = 0 throughout.
REQ-052 Collision: CPU write 8'hAA to 12'h010 in CPU_ACC when BUS_REQ rises -> write completes (RAM[12'h010] = 8'hAA), then BUS_ACK asserts with no lost video cycles after the grant.
REQ-053 Blocked CPU: read captured while BUS_ACK = 1 -> CPU_WAIT_N stays low until BUS_REQ falls, then the read completes within 3 clocks.
REQ-054 Posted write (macro on): write 8'h11 to 12'hFFF during video -> CPU_WAIT_N never low; RAM[12'hFFF] = 8'h11 within 4 clocks of BUS_REQ falling. Macro off -> CPU_WAIT_N low until the write completes.
REQ-055 Reset mid-access: RST_N low during CPU_ACC of a write -> RAM_WE = 0 and CPU_WAIT_N = 1 next clock; the RAM location is unchanged.
